ahb_cmd_sequencer: RTL and testbench

- Sits directly downstream of the 23-bit instruction memory inside the AHB master.
- Drives `pc` into the memory and decodes each returned instruction word: WRITE[22], BURST[21:19], SEL[18], ADDR[17:8], DATA[7:0].
- Expands each instruction into one AHB beat command per beat, over a valid/ready handshake, to the AHB master transfer engine.
- Runs from pc 0 up to PROG_LEN, then reports done.

---
 rtl/ahb_cmd_sequencer_if.sv | 21 ++
 rtl/ahb_cmd_sequencer.sv | 152 +++++++++++++++
 tb/tb_ahb_cmd_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_cmd_sequencer_if.sv
// rtl/ahb_cmd_sequencer_if.sv - beat command channel between sequencer and AHB transfer engine
interface ahb_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [2:0] cmd_burst;
    logic       cmd_seq;
    logic       cmd_sel;
    logic [9:0] cmd_addr;
    logic [7:0] cmd_wdata;

    modport master (
        output cmd_valid, cmd_write, cmd_burst, cmd_seq, cmd_sel, cmd_addr, cmd_wdata,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_burst, cmd_seq, cmd_sel, cmd_addr, cmd_wdata,
        output cmd_ready
    );
endinterface

// File: rtl/ahb_cmd_sequencer.sv
// rtl/ahb_cmd_sequencer.sv - expands instruction memory words into AHB beat commands
// Optional SINGLE_STEP_EN adds a step input that gates each LOAD -> ISSUE transition.
module ahb_cmd_sequencer #(
    parameter int PROG_LEN = 20
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic                        start,
`ifdef SINGLE_STEP_EN
    input  logic                        step,
`endif
    output logic [9:0]                  pc,
    input  logic [22:0]                 instruction,
    ahb_cmd_sequencer_if.master         cmd,
    input  logic                        rdata_valid,
    input  logic [7:0]                  rdata,
    output logic [7:0]                  last_rdata,
    output logic [7:0]                  rd_count,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] beat_cnt;
    logic [3:0] hdr_nm1;
    logic       hdr_write;
    logic       hdr_sel;
    logic [2:0] hdr_burst;
    logic [9:0] hdr_addr;

    logic       start_go;
    logic       load_go;
    logic       accept;
    logic       last_beat;
    logic       end_of_prog;
    logic       is_wrap;
    logic [9:0] pc_inc;
    logic [9:0] incr_addr;
    logic [9:0] wrap_mask;
    logic [9:0] beat_addr;

    // Beats minus one, which doubles as the WRAP boundary mask.
    function automatic logic [3:0] beats_minus_one(input logic [2:0] burst);
        case (burst[2:1])
            2'b00:   return 4'd0;
            2'b01:   return 4'd3;
            2'b10:   return 4'd7;
            default: return 4'd15;
        endcase
    endfunction

`ifdef SINGLE_STEP_EN
    assign load_go = step;
`else
    assign load_go = 1'b1;
`endif

    assign start_go    = start && ((state == IDLE) || (state == DONE));
    assign accept      = (state == ISSUE) && cmd.cmd_ready;
    assign last_beat   = (beat_cnt == hdr_nm1);
    assign pc_inc      = pc + 10'd1;
    assign end_of_prog = ({1'b0, pc_inc} >= 11'(PROG_LEN));

    assign is_wrap   = !hdr_burst[0] && (hdr_burst[2:1] != 2'b00);
    assign incr_addr = hdr_addr + {6'd0, beat_cnt};
    assign wrap_mask = {6'd0, hdr_nm1};
    assign beat_addr = is_wrap ? ((hdr_addr & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = LOAD;
            LOAD:       if (load_go) state_nxt = ISSUE;
            ISSUE:      if (accept && last_beat) state_nxt = end_of_prog ? DONE : LOAD;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pc         <= 10'd0;
            beat_cnt   <= 4'd0;
            hdr_nm1    <= 4'd0;
            hdr_write  <= 1'b0;
            hdr_sel    <= 1'b0;
            hdr_burst  <= 3'd0;
            hdr_addr   <= 10'd0;
            last_rdata <= 8'd0;
            rd_count   <= 8'd0;
        end else begin
            if (start_go)
                pc <= 10'd0;
            else if (accept)
                pc <= pc_inc;

            if ((state == LOAD) && load_go) begin
                hdr_write <= instruction[22];
                hdr_burst <= instruction[21:19];
                hdr_sel   <= instruction[18];
                hdr_addr  <= instruction[17:8];
                hdr_nm1   <= beats_minus_one(instruction[21:19]);
                beat_cnt  <= 4'd0;
            end else if (accept) begin
                beat_cnt  <= last_beat ? 4'd0 : beat_cnt + 4'd1;
            end

            if (rdata_valid)
                last_rdata <= rdata;

            // A restart clears the read count even if data arrives in the same cycle.
            if (start_go)
                rd_count <= 8'd0;
            else if (rdata_valid)
                rd_count <= rd_count + 8'd1;
        end
    end

    always_comb begin
        cmd.cmd_valid = 1'b0;
        cmd.cmd_write = 1'b0;
        cmd.cmd_burst = 3'd0;
        cmd.cmd_seq   = 1'b0;
        cmd.cmd_sel   = 1'b0;
        cmd.cmd_addr  = 10'd0;
        cmd.cmd_wdata = 8'd0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            LOAD: busy = 1'b1;
            ISSUE: begin
                busy          = 1'b1;
                cmd.cmd_valid = 1'b1;
                cmd.cmd_write = hdr_write;
                cmd.cmd_burst = hdr_burst;
                cmd.cmd_seq   = (beat_cnt != 4'd0);
                cmd.cmd_sel   = hdr_sel;
                cmd.cmd_addr  = beat_addr;
                cmd.cmd_wdata = instruction[7:0];
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_cmd_sequencer.sv
// tb/tb_ahb_cmd_sequencer.sv - directed self-checking bench for ahb_cmd_sequencer
module tb_ahb_cmd_sequencer;

    localparam logic [22:0] SINGLE_INS = {1'b1, 3'b000, 1'b0, 10'h005, 8'h05};

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start;
    logic        rdata_valid;
    logic [7:0]  rdata;
    logic [9:0]  pc, pc1;
    logic [22:0] instruction, instruction1;
    logic [7:0]  last_rdata, last_rdata1, rd_count, rd_count1;
    logic        busy, done, busy1, done1;
    logic [22:0] mem [0:1023];
    int          passed = 0;
    int          total  = 0;
`ifdef SINGLE_STEP_EN
    logic        step = 1'b1;
`endif

    always #5 HCLK = ~HCLK;

    ahb_cmd_sequencer_if bus();
    ahb_cmd_sequencer_if bus1();

    assign instruction  = mem[pc];
    assign instruction1 = (pc1 == 10'd0) ? SINGLE_INS : 23'd0;

    ahb_cmd_sequencer #(.PROG_LEN(20)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .pc(pc), .instruction(instruction), .cmd(bus.master),
        .rdata_valid(rdata_valid), .rdata(rdata), .last_rdata(last_rdata),
        .rd_count(rd_count), .busy(busy), .done(done)
    );

    ahb_cmd_sequencer #(.PROG_LEN(1)) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .pc(pc1), .instruction(instruction1), .cmd(bus1.master),
        .rdata_valid(1'b0), .rdata(8'h00), .last_rdata(last_rdata1),
        .rd_count(rd_count1), .busy(busy1), .done(done1)
    );

    function automatic logic [22:0] ins(input logic w, input logic [2:0] b, input logic s,
                                        input logic [9:0] a, input logic [7:0] d);
        return {w, b, s, a, d};
    endfunction

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (bus.cmd_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus.cmd_valid); else passed++;
        total++; if (pc !== 10'd0) $display("FAIL rst_pc got %h exp 000", pc); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else passed++;
        total++; if (rd_count !== 8'd0) $display("FAIL rst_rdcnt got %h exp 00", rd_count); else passed++;
        total++; if (last_rdata !== 8'd0) $display("FAIL rst_lastrd got %h exp 00", last_rdata); else passed++;
    endtask

    task automatic test_single();
        pulse_start();
        total++; if (bus1.cmd_valid !== 1'b0) $display("FAIL single_load_valid got %b exp 0", bus1.cmd_valid); else passed++;
        tick();
        total++; if (bus1.cmd_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", bus1.cmd_valid); else passed++;
        total++; if (bus1.cmd_addr !== 10'h005) $display("FAIL single_addr got %h exp 005", bus1.cmd_addr); else passed++;
        total++; if (bus1.cmd_wdata !== 8'h05) $display("FAIL single_wdata got %h exp 05", bus1.cmd_wdata); else passed++;
        total++; if (bus1.cmd_seq !== 1'b0) $display("FAIL single_seq got %b exp 0", bus1.cmd_seq); else passed++;
        total++; if (bus1.cmd_write !== 1'b1) $display("FAIL single_write got %b exp 1", bus1.cmd_write); else passed++;
        tick();
        total++; if (done1 !== 1'b1) $display("FAIL single_done got %b exp 1", done1); else passed++;
        total++; if (busy1 !== 1'b0) $display("FAIL single_busy got %b exp 0", busy1); else passed++;
        total++; if (pc1 !== 10'd1) $display("FAIL single_pc got %h exp 001", pc1); else passed++;
        for (int c = 0; c < 200 && !done; c++) tick();
        total++; if (done !== 1'b1) $display("FAIL single_main_done got %b exp 1", done); else passed++;
    endtask

    task automatic test_burst();
        logic [9:0] wa [4] = '{10'h006, 10'h007, 10'h004, 10'h005};
        logic [7:0] iw [4] = '{8'h02, 8'h11, 8'h22, 8'h33};
        logic [7:0] ww [4] = '{8'ha0, 8'ha1, 8'ha2, 8'ha3};
        pulse_start();
        total++; if (busy !== 1'b1 || bus.cmd_valid !== 1'b0) $display("FAIL burst_load got busy=%b valid=%b exp 1/0", busy, bus.cmd_valid); else passed++;
        tick();
        total++; if (bus.cmd_burst !== 3'b011 || bus.cmd_sel !== 1'b1) $display("FAIL incr4_hdr got burst=%h sel=%b exp 3/1", bus.cmd_burst, bus.cmd_sel); else passed++;
        for (int k = 0; k < 4; k++) begin
            total++; if (bus.cmd_valid !== 1'b1) $display("FAIL incr4_valid beat %0d got %b exp 1", k, bus.cmd_valid); else passed++;
            total++; if (bus.cmd_addr !== 10'(k + 1)) $display("FAIL incr4_addr beat %0d got %h exp %h", k, bus.cmd_addr, 10'(k + 1)); else passed++;
            total++; if (bus.cmd_wdata !== iw[k]) $display("FAIL incr4_wdata beat %0d got %h exp %h", k, bus.cmd_wdata, iw[k]); else passed++;
            total++; if (bus.cmd_seq !== (k != 0)) $display("FAIL incr4_seq beat %0d got %b exp %b", k, bus.cmd_seq, k != 0); else passed++;
            total++; if (pc !== 10'(k)) $display("FAIL incr4_pc beat %0d got %h exp %h", k, pc, 10'(k)); else passed++;
            tick();
        end
        total++; if (bus.cmd_valid !== 1'b0 || pc !== 10'd4) $display("FAIL bubble got valid=%b pc=%h exp 0/004", bus.cmd_valid, pc); else passed++;
        tick();
        for (int k = 0; k < 4; k++) begin
            total++; if (bus.cmd_addr !== wa[k]) $display("FAIL wrap4_addr beat %0d got %h exp %h", k, bus.cmd_addr, wa[k]); else passed++;
            total++; if (bus.cmd_wdata !== ww[k]) $display("FAIL wrap4_wdata beat %0d got %h exp %h", k, bus.cmd_wdata, ww[k]); else passed++;
            tick();
        end
        tick();
        for (int k = 0; k < 16; k++) begin
            total++; if (bus.cmd_addr !== 10'(10'h3ff + k)) $display("FAIL incr16_addr beat %0d got %h exp %h", k, bus.cmd_addr, 10'(10'h3ff + k)); else passed++;
            total++; if (bus.cmd_write !== 1'b0 || bus.cmd_valid !== 1'b1) $display("FAIL incr16_ctl beat %0d got write=%b valid=%b exp 0/1", k, bus.cmd_write, bus.cmd_valid); else passed++;
            total++; if (pc !== 10'(8 + k)) $display("FAIL incr16_pc beat %0d got %h exp %h", k, pc, 10'(8 + k)); else passed++;
            tick();
        end
        total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL end_done got done=%b busy=%b exp 1/0", done, busy); else passed++;
        total++; if (pc !== 10'd24) $display("FAIL end_pc got %h exp 018", pc); else passed++;
    endtask

    task automatic test_stall();
        pulse_start();
        tick();
        tick();
        tick();
        total++; if (bus.cmd_addr !== 10'h003 || pc !== 10'd2) $display("FAIL stall_pre got addr=%h pc=%h exp 003/002", bus.cmd_addr, pc); else passed++;
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rdata_valid = (i == 1) || (i == 3);
            rdata       = (i == 1) ? 8'ha5 : 8'h3c;
            start       = (i == 3);
            tick();
            rdata_valid = 1'b0;
            start       = 1'b0;
            total++; if (bus.cmd_valid !== 1'b1) $display("FAIL stall_valid cyc %0d got %b exp 1", i, bus.cmd_valid); else passed++;
            total++; if (bus.cmd_addr !== 10'h003) $display("FAIL stall_addr cyc %0d got %h exp 003", i, bus.cmd_addr); else passed++;
            total++; if (bus.cmd_wdata !== 8'h22) $display("FAIL stall_wdata cyc %0d got %h exp 22", i, bus.cmd_wdata); else passed++;
            total++; if (pc !== 10'd2) $display("FAIL stall_pc cyc %0d got %h exp 002", i, pc); else passed++;
        end
        bus.cmd_ready = 1'b1;
        tick();
        total++; if (bus.cmd_addr !== 10'h004 || pc !== 10'd3) $display("FAIL stall_release got addr=%h pc=%h exp 004/003", bus.cmd_addr, pc); else passed++;
        for (int c = 0; c < 200 && !done; c++) tick();
        total++; if (done !== 1'b1) $display("FAIL stall_done got %b exp 1", done); else passed++;
        total++; if (last_rdata !== 8'h3c) $display("FAIL rd_last got %h exp 3c", last_rdata); else passed++;
        total++; if (rd_count !== 8'd2) $display("FAIL rd_count got %h exp 02", rd_count); else passed++;
    endtask

    task automatic test_restart_and_reset();
        start       = 1'b1;
        rdata_valid = 1'b1;
        rdata       = 8'h77;
        tick();
        start       = 1'b0;
        rdata_valid = 1'b0;
        total++; if (rd_count !== 8'd0) $display("FAIL rd_prio got %h exp 00", rd_count); else passed++;
        total++; if (last_rdata !== 8'h77) $display("FAIL rd_prio_data got %h exp 77", last_rdata); else passed++;
        total++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL restart got done=%b busy=%b exp 0/1", done, busy); else passed++;
        tick();
        tick();
        total++; if (bus.cmd_valid !== 1'b1 || pc !== 10'd1) $display("FAIL pre_rst got valid=%b pc=%h exp 1/001", bus.cmd_valid, pc); else passed++;
        HRESETn = 1'b0;
        #1;
        total++; if (bus.cmd_valid !== 1'b0) $display("FAIL async_rst_valid got %b exp 0", bus.cmd_valid); else passed++;
        total++; if (pc !== 10'd0) $display("FAIL async_rst_pc got %h exp 000", pc); else passed++;
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL async_rst_flags got busy=%b done=%b exp 0/0", busy, done); else passed++;
        tick();
        HRESETn = 1'b1;
        tick();
        tick();
        total++; if (busy !== 1'b0 || bus.cmd_valid !== 1'b0) $display("FAIL post_rst_idle got busy=%b valid=%b exp 0/0", busy, bus.cmd_valid); else passed++;
    endtask

    initial begin
        HRESETn       = 1'b0;
        start         = 1'b0;
        rdata_valid   = 1'b0;
        rdata         = 8'h00;
        bus.cmd_ready  = 1'b1;
        bus1.cmd_ready = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 23'd0;
        mem[0] = ins(1'b1, 3'b011, 1'b1, 10'h001, 8'h02);
        mem[1] = ins(1'b0, 3'b000, 1'b0, 10'h000, 8'h11);
        mem[2] = ins(1'b0, 3'b000, 1'b0, 10'h000, 8'h22);
        mem[3] = ins(1'b0, 3'b000, 1'b0, 10'h000, 8'h33);
        mem[4] = ins(1'b1, 3'b010, 1'b0, 10'h006, 8'ha0);
        mem[5] = ins(1'b0, 3'b000, 1'b0, 10'h000, 8'ha1);
        mem[6] = ins(1'b0, 3'b000, 1'b0, 10'h000, 8'ha2);
        mem[7] = ins(1'b0, 3'b000, 1'b0, 10'h000, 8'ha3);
        mem[8] = ins(1'b0, 3'b111, 1'b1, 10'h3ff, 8'h00);
        tick();
        tick();
        test_reset();
        HRESETn = 1'b1;
        tick();
        test_single();
        test_burst();
        test_stall();
        test_restart_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
